// File: rtl/pilot_tone_monitor_if.sv
// Signal bundle between the pilot tone monitor and its CSR/stimulus side.
// The master drives the tone and the expected widths; the slave (the monitor) reports status.
interface pilot_tone_monitor_if #(
  parameter int unsigned COUNTER_WIDTH = 10,
  parameter int unsigned ERR_WIDTH     = 16
);
  logic                     pilotToneIn;
  logic [COUNTER_WIDTH-1:0] expectedHi;
  logic [COUNTER_WIDTH-1:0] expectedLo;
  logic                     errClear;
  logic [COUNTER_WIDTH-1:0] hiWidth;
  logic [COUNTER_WIDTH-1:0] loWidth;
  logic                     periodStrobe;
  logic                     locked;
  logic [ERR_WIDTH-1:0]     errCount;

  modport master (
    output pilotToneIn, expectedHi, expectedLo, errClear,
    input  hiWidth, loWidth, periodStrobe, locked, errCount
  );

  modport slave (
    input  pilotToneIn, expectedHi, expectedLo, errClear,
    output hiWidth, loWidth, periodStrobe, locked, errCount
  );
endinterface

// File: rtl/pilot_tone_monitor.sv
// Measures pilot tone high/low phase widths in evrClk cycles, checks them against the
// programmed divide values and reports lock status plus a saturating error count.
module pilot_tone_monitor #(
  parameter int unsigned COUNTER_WIDTH = 10,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned ERR_WIDTH     = 16
) (
  input logic                 evrClk,
  input logic                 evrReset_n,
  pilot_tone_monitor_if.slave bus
);

  localparam logic [COUNTER_WIDTH-1:0] CntMax  = '1;
  localparam logic [COUNTER_WIDTH-1:0] CntOne  = COUNTER_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0]     ErrOne  = ERR_WIDTH'(1);
  localparam logic [7:0]               LockCnt = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {StSync, StMeasHi, StMeasLo} state_e;

  logic                     r_s1, r_s2, r_p;
  logic [1:0]               r_fill;
  logic                     r_armed;
  logic [COUNTER_WIDTH-1:0] r_exp_hi, r_exp_lo;
  state_e                   r_state, w_state_d;
  logic [COUNTER_WIDTH-1:0] r_cnt, w_cnt_d;
  logic                     r_hi_ok, w_hi_ok_d;
  logic [7:0]               r_good, w_good_d;
  logic                     r_locked, w_locked_d;
  logic [ERR_WIDTH-1:0]     r_err, w_err_d;
  logic [COUNTER_WIDTH-1:0] r_hi_w, w_hi_w_d;
  logic [COUNTER_WIDTH-1:0] r_lo_w, w_lo_w_d;
  logic                     r_strobe, w_strobe_d;
  logic                     w_bad, w_good_per;

  logic w_edge, w_rise, w_fall, w_disabled, w_exp_chg;
  assign w_edge     = r_s2 ^ r_p;
  assign w_rise     = w_edge & r_s2;
  assign w_fall     = w_edge & ~r_s2;
  assign w_disabled = (r_exp_hi == '0) || (r_exp_lo == '0);
  assign w_exp_chg  = (bus.expectedHi != r_exp_hi) || (bus.expectedLo != r_exp_lo);

  // s2 holds a genuine sample only once r_fill[1] is set; a genuine low must be seen before
  // a rising edge may start a measurement, so the level present at reset release is discarded.
  always_ff @(posedge evrClk or negedge evrReset_n) begin
    if (!evrReset_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_p      <= 1'b0;
      r_fill   <= 2'b00;
      r_armed  <= 1'b0;
      r_exp_hi <= '0;
      r_exp_lo <= '0;
    end else begin
      r_s1     <= bus.pilotToneIn;
      r_s2     <= r_s1;
      r_p      <= r_s2;
      r_fill   <= {r_fill[0], 1'b1};
      r_exp_hi <= bus.expectedHi;
      r_exp_lo <= bus.expectedLo;
      if (r_fill[1] && !r_s2) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge evrClk or negedge evrReset_n) begin
    if (!evrReset_n) begin
      r_state  <= StSync;
      r_cnt    <= '0;
      r_hi_ok  <= 1'b0;
      r_good   <= '0;
      r_locked <= 1'b0;
      r_err    <= '0;
      r_hi_w   <= '0;
      r_lo_w   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_hi_ok  <= w_hi_ok_d;
      r_good   <= w_good_d;
      r_locked <= w_locked_d;
      r_err    <= w_err_d;
      r_hi_w   <= w_hi_w_d;
      r_lo_w   <= w_lo_w_d;
      r_strobe <= w_strobe_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_hi_ok_d  = r_hi_ok;
    w_good_d   = r_good;
    w_locked_d = r_locked;
    w_hi_w_d   = r_hi_w;
    w_lo_w_d   = r_lo_w;
    w_strobe_d = 1'b0;
    w_bad      = 1'b0;
    w_good_per = 1'b0;
    if (w_disabled || w_exp_chg) begin
      w_state_d  = StSync;
      w_good_d   = '0;
      w_locked_d = 1'b0;
    end else begin
      unique case (r_state)
        StSync: begin
          if (w_rise && r_armed) begin
            w_state_d = StMeasHi;
            w_cnt_d   = CntOne;
          end
        end
        StMeasHi: begin
          if (w_fall) begin
            w_hi_w_d  = r_cnt;
            w_hi_ok_d = (r_cnt == r_exp_hi);
            w_bad     = (r_cnt != r_exp_hi);
            w_cnt_d   = CntOne;
            w_state_d = StMeasLo;
          end else if (r_cnt == CntMax) begin
            w_bad     = 1'b1;
            w_state_d = StSync;
          end else begin
            w_cnt_d = r_cnt + CntOne;
          end
        end
        StMeasLo: begin
          if (w_rise) begin
            w_lo_w_d   = r_cnt;
            w_strobe_d = 1'b1;
            w_bad      = (r_cnt != r_exp_lo);
            w_good_per = (r_cnt == r_exp_lo) && r_hi_ok;
            w_cnt_d    = CntOne;
            w_state_d  = StMeasHi;
          end else if (r_cnt == CntMax) begin
            w_bad     = 1'b1;
            w_state_d = StSync;
          end else begin
            w_cnt_d = r_cnt + CntOne;
          end
        end
        default: w_state_d = StSync;
      endcase
      if (w_bad) begin
        w_good_d   = '0;
        w_locked_d = 1'b0;
      end else if (w_good_per) begin
        if (r_good < LockCnt) w_good_d = r_good + 8'd1;
        if (w_good_d == LockCnt) w_locked_d = 1'b1;
      end
    end
  end

  // A clear coinciding with an error event wins.
  always_comb begin
    w_err_d = r_err;
    if (bus.errClear) begin
      w_err_d = '0;
    end else if (w_bad && (r_err != '1)) begin
      w_err_d = r_err + ErrOne;
    end
  end

  assign bus.hiWidth      = r_hi_w;
  assign bus.loWidth      = r_lo_w;
  assign bus.periodStrobe = r_strobe;
  assign bus.locked       = r_locked;
  assign bus.errCount     = r_err;

endmodule

// File: tb/tb_pilot_tone_monitor.sv
// Scoreboard bench for pilot_tone_monitor: each driven period pushes its expected status,
// which is popped and compared when periodStrobe fires. A second instance has ERR_WIDTH=2.
module tb_pilot_tone_monitor;

  localparam int unsigned CW = 10;
  localparam int unsigned LC = 4;

  logic evrClk = 1'b0;
  logic evrReset_n = 1'b0;

  pilot_tone_monitor_if #(.COUNTER_WIDTH(CW), .ERR_WIDTH(16)) bus ();
  pilot_tone_monitor_if #(.COUNTER_WIDTH(CW), .ERR_WIDTH(2))  bus2 ();

  assign bus2.pilotToneIn = bus.pilotToneIn;
  assign bus2.expectedHi  = bus.expectedHi;
  assign bus2.expectedLo  = bus.expectedLo;
  assign bus2.errClear    = bus.errClear;

  pilot_tone_monitor #(.COUNTER_WIDTH(CW), .LOCK_COUNT(LC), .ERR_WIDTH(16)) u_dut (
    .evrClk    (evrClk),
    .evrReset_n(evrReset_n),
    .bus       (bus)
  );

  pilot_tone_monitor #(.COUNTER_WIDTH(CW), .LOCK_COUNT(LC), .ERR_WIDTH(2)) u_dut2 (
    .evrClk    (evrClk),
    .evrReset_n(evrReset_n),
    .bus       (bus2)
  );

  always #5 evrClk = ~evrClk;

  typedef struct {
    int hi;
    int lo;
    int lk;
    int err;
    int err2;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Period-level reference state
  int m_eh, m_el, m_good, m_locked, m_err, m_err2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_vec++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge evrClk);
      #1;
    end
  endtask

  task automatic phase(input bit lvl, input int n);
    bus.pilotToneIn = lvl;
    tick(n);
  endtask

  // Low phase with errClear sampled on the edge that registers the preceding high check
  task automatic lo_clr(input int n);
    bus.pilotToneIn = 1'b0;
    tick(2);
    bus.errClear = 1'b1;
    tick(1);
    bus.errClear = 1'b0;
    tick(n - 3);
  endtask

  task automatic bad();
    if (m_err != 65535) m_err++;
    if (m_err2 != 3) m_err2++;
    m_good   = 0;
    m_locked = 0;
  endtask

  task automatic period(input int hi, input int lo, input bit clr);
    exp_t e;
    bit   hok, lok;
    hok = (hi == m_eh);
    lok = (lo == m_el);
    if (!hok) bad();
    if (clr) begin
      m_err  = 0;
      m_err2 = 0;
    end
    if (!lok) bad();
    else if (hok) begin
      if (m_good < LC) m_good++;
      if (m_good == LC) m_locked = 1;
    end
    e.hi = hi; e.lo = lo; e.lk = m_locked; e.err = m_err; e.err2 = m_err2;
    sb.push_back(e);
    phase(1'b1, hi);
    if (clr) lo_clr(lo);
    else phase(1'b0, lo);
  endtask

  always @(negedge evrClk) begin
    if (bus.periodStrobe === 1'b1) begin
      exp_t e;
      chk("strobe_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("hiWidth", bus.hiWidth, e.hi);
        chk("loWidth", bus.loWidth, e.lo);
        chk("locked", bus.locked, e.lk);
        chk("errCount", bus.errCount, e.err);
        chk("errCount_w2", bus2.errCount, e.err2);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.pilotToneIn = 1'b0;
    bus.expectedHi  = 10'd3;
    bus.expectedLo  = 10'd5;
    bus.errClear    = 1'b0;
    m_eh = 3; m_el = 5; m_good = 0; m_locked = 0; m_err = 0; m_err2 = 0;
    evrReset_n = 1'b0;
    tick(3);
    chk("rst_hiWidth", bus.hiWidth, 0);
    chk("rst_loWidth", bus.loWidth, 0);
    chk("rst_strobe", bus.periodStrobe, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_errCount", bus.errCount, 0);
    evrReset_n = 1'b1;
    phase(1'b0, 6);

    // Ideal 3/5, then one stretched high phase and relock
    repeat (6) period(3, 5, 1'b0);
    period(4, 5, 1'b0);
    repeat (5) period(3, 5, 1'b0);

    // Stuck low: timeout in MEAS_LO, then idle in SYNC
    phase(1'b1, 3);
    bus.pilotToneIn = 1'b0;
    tick(1020);
    chk("to_early_err", bus.errCount, m_err);
    chk("to_early_lock", bus.locked, m_locked);
    tick(10);
    bad();
    chk("to_err", bus.errCount, m_err);
    chk("to_lock", bus.locked, m_locked);
    chk("to_err_w2", bus2.errCount, m_err2);
    tick(1100);
    chk("to_hold_err", bus.errCount, m_err);

    // Relock at 3/5, then retarget to 7/7
    repeat (4) period(3, 5, 1'b0);
    phase(1'b1, 3);
    bus.expectedHi = 10'd7;
    bus.expectedLo = 10'd7;
    m_eh = 7; m_el = 7; m_good = 0; m_locked = 0;
    phase(1'b0, 7);
    chk("chg_locked", bus.locked, 0);
    chk("chg_err", bus.errCount, m_err);
    repeat (4) period(7, 7, 1'b0);

    // Clear while locked, five errors, then clear coinciding with a mismatch
    period(7, 7, 1'b1);
    period(8, 7, 1'b0);
    period(7, 6, 1'b0);
    period(7, 9, 1'b0);
    period(8, 7, 1'b0);
    period(7, 8, 1'b0);
    period(8, 7, 1'b1);
    repeat (2) period(7, 7, 1'b0);
    phase(1'b1, 4);
    chk("sb_drain", sb.size(), 0);
    chk("pre_rst_hi", bus.hiWidth, 7);

    // Reset mid-MEAS_HI
    #2;
    evrReset_n = 1'b0;
    #1;
    chk("arst_hiWidth", bus.hiWidth, 0);
    chk("arst_loWidth", bus.loWidth, 0);
    chk("arst_locked", bus.locked, 0);
    chk("arst_errCount", bus.errCount, 0);
    chk("arst_strobe", bus.periodStrobe, 0);
    m_good = 0; m_locked = 0; m_err = 0; m_err2 = 0;
    tick(2);
    evrReset_n = 1'b1;
    phase(1'b1, 5);
    phase(1'b0, 7);
    chk("post_rst_hi", bus.hiWidth, 0);
    repeat (2) period(7, 7, 1'b0);
    phase(1'b1, 4);
    chk("sb_end", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
